// File: rtl/cpu_record_extractor_pkg.sv
// rtl/cpu_record_extractor_pkg.sv - shared state encodings, ASCII and verdict codes for the record extractor
package cpu_record_extractor_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_TIME,
    S_PC,
    S_SEP,
    S_TGT,
    S_ARROW,
    S_EQ,
    S_DATA,
    S_DONE
  } state_e;

  localparam logic [7:0] CH_CARET  = 8'h5E;
  localparam logic [7:0] CH_AT     = 8'h40;
  localparam logic [7:0] CH_COLON  = 8'h3A;
  localparam logic [7:0] CH_STAR   = 8'h2A;
  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_LT     = 8'h3C;
  localparam logic [7:0] CH_EQ     = 8'h3D;
  localparam logic [7:0] CH_HASH   = 8'h23;
  localparam logic [7:0] CH_SPACE  = 8'h20;

  localparam logic [1:0] FT_NONE = 2'd0;
  localparam logic [1:0] FT_REG  = 2'd1;
  localparam logic [1:0] FT_MEM  = 2'd2;

endpackage

// File: rtl/cpu_record_extractor_ascii_digit_decode.sv
// rtl/cpu_record_extractor_ascii_digit_decode.sv - combinational ASCII decimal/lowercase-hex digit classifier
module ascii_digit_decode (
  input  logic [7:0] char_i,
  output logic       is_dec_o,
  output logic       is_hex_o,
  output logic [3:0] nibble_o
);

  always_comb begin
    is_dec_o = 1'b0;
    is_hex_o = 1'b0;
    nibble_o = 4'h0;
    if (char_i >= 8'h30 && char_i <= 8'h39) begin
      is_dec_o = 1'b1;
      is_hex_o = 1'b1;
      nibble_o = 4'(char_i - 8'h30);
    end else if (char_i >= 8'h61 && char_i <= 8'h66) begin
      is_hex_o = 1'b1;
      nibble_o = 4'(char_i - 8'h57);
    end
  end

endmodule

// File: rtl/cpu_record_extractor.sv
// rtl/cpu_record_extractor.sv - tentative trace-record field decoder that commits only on the checker's verdict
module cpu_record_extractor
  import cpu_record_extractor_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [7:0]       char_i,
  input  logic [1:0]       format_type_i,
  output logic             rec_valid_o,
  output logic [1:0]       rec_kind_o,
  output logic [15:0]      rec_time_o,
  output logic [31:0]      rec_pc_o,
  output logic [31:0]      rec_target_o,
  output logic [31:0]      rec_data_o,
  output logic [CNT_W-1:0] reg_cnt_o,
  output logic [CNT_W-1:0] mem_cnt_o,
  output logic             desync_o
);

  logic       is_dec, is_hex;
  logic [3:0] nib;

  ascii_digit_decode u_digit (
    .char_i   (char_i),
    .is_dec_o (is_dec),
    .is_hex_o (is_hex),
    .nibble_o (nib)
  );

  state_e          state_q;
  logic [15:0]     time_q;
  logic [31:0]     pc_q, target_q, data_q;
  logic            kind_mem_q, data_seen_q;
  logic            rec_valid_q, desync_q;
  logic [1:0]      rec_kind_q;
  logic [15:0]     rec_time_q;
  logic [31:0]     rec_pc_q, rec_target_q, rec_data_q;
  logic [CNT_W-1:0] reg_cnt_q, mem_cnt_q;

  logic [15:0] time_d;
  logic [31:0] pc_d, tgt_hex_d, tgt_dec_d, data_d;

  always_comb begin
    time_d    = time_q * 16'd10 + {12'd0, nib};
    pc_d      = {pc_q[27:0], nib};
    tgt_hex_d = {target_q[27:0], nib};
    tgt_dec_d = target_q * 32'd10 + {28'd0, nib};
    data_d    = {data_q[27:0], nib};
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      time_q       <= '0;
      pc_q         <= '0;
      target_q     <= '0;
      data_q       <= '0;
      kind_mem_q   <= 1'b0;
      data_seen_q  <= 1'b0;
      rec_valid_q  <= 1'b0;
      rec_kind_q   <= '0;
      rec_time_q   <= '0;
      rec_pc_q     <= '0;
      rec_target_q <= '0;
      rec_data_q   <= '0;
      reg_cnt_q    <= '0;
      mem_cnt_q    <= '0;
      desync_q     <= 1'b0;
    end else begin
      rec_valid_q <= 1'b0;
      // Commit reads the shadow as it stood before this edge, so a '^' here cannot corrupt it.
      if (format_type_i != FT_NONE) begin
        if (state_q == S_DONE) begin
          rec_valid_q  <= 1'b1;
          rec_kind_q   <= format_type_i;
          rec_time_q   <= time_q;
          rec_pc_q     <= pc_q;
          rec_target_q <= target_q;
          rec_data_q   <= data_q;
          if (format_type_i == FT_REG && reg_cnt_q != '1) reg_cnt_q <= reg_cnt_q + 1'b1;
          if (format_type_i == FT_MEM && mem_cnt_q != '1) mem_cnt_q <= mem_cnt_q + 1'b1;
        end else begin
          desync_q <= 1'b1;
        end
      end

      case (state_q)
        S_IDLE, S_DONE: begin
          if (char_i == CH_CARET) begin
            state_q     <= S_TIME;
            time_q      <= '0;
            pc_q        <= '0;
            target_q    <= '0;
            data_q      <= '0;
            kind_mem_q  <= 1'b0;
            data_seen_q <= 1'b0;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_TIME: begin
          if (is_dec)                 time_q  <= time_d;
          else if (char_i == CH_AT)   state_q <= S_PC;
          else                        state_q <= S_IDLE;
        end
        S_PC: begin
          if (is_hex)                  pc_q    <= pc_d;
          else if (char_i == CH_COLON) state_q <= S_SEP;
          else                         state_q <= S_IDLE;
        end
        S_SEP: begin
          if (char_i == CH_SPACE) begin
            state_q <= S_SEP;
          end else if (char_i == CH_STAR) begin
            state_q    <= S_TGT;
            kind_mem_q <= 1'b1;
          end else if (char_i == CH_DOLLAR) begin
            state_q    <= S_TGT;
            kind_mem_q <= 1'b0;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_TGT: begin
          if (kind_mem_q && is_hex)       target_q <= tgt_hex_d;
          else if (!kind_mem_q && is_dec) target_q <= tgt_dec_d;
          else if (char_i == CH_SPACE)    state_q  <= S_ARROW;
          else if (char_i == CH_LT)       state_q  <= S_EQ;
          else                            state_q  <= S_IDLE;
        end
        S_ARROW: begin
          if (char_i == CH_SPACE)      state_q <= S_ARROW;
          else if (char_i == CH_LT)    state_q <= S_EQ;
          else                         state_q <= S_IDLE;
        end
        S_EQ: begin
          state_q <= (char_i == CH_EQ) ? S_DATA : S_IDLE;
        end
        S_DATA: begin
          if (is_hex) begin
            data_q      <= data_d;
            data_seen_q <= 1'b1;
          end else if (char_i == CH_SPACE && !data_seen_q) begin
            state_q <= S_DATA;
          end else if (char_i == CH_HASH) begin
            state_q <= S_DONE;
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rec_valid_o  = rec_valid_q;
  assign rec_kind_o   = rec_kind_q;
  assign rec_time_o   = rec_time_q;
  assign rec_pc_o     = rec_pc_q;
  assign rec_target_o = rec_target_q;
  assign rec_data_o   = rec_data_q;
  assign reg_cnt_o    = reg_cnt_q;
  assign mem_cnt_o    = mem_cnt_q;
  assign desync_o     = desync_q;

endmodule

// File: tb/tb_cpu_record_extractor.sv
// tb/tb_cpu_record_extractor.sv - directed self-checking bench for cpu_record_extractor
module tb_cpu_record_extractor;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [7:0]  char_i;
  logic [1:0]  format_type_i;
  logic        rec_valid_o;
  logic [1:0]  rec_kind_o;
  logic [15:0] rec_time_o;
  logic [31:0] rec_pc_o, rec_target_o, rec_data_o;
  logic [1:0]  reg_cnt_o, mem_cnt_o;
  logic        desync_o;

  int checks   = 0;
  int failures = 0;

  cpu_record_extractor #(.CNT_W(2)) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .char_i        (char_i),
    .format_type_i (format_type_i),
    .rec_valid_o   (rec_valid_o),
    .rec_kind_o    (rec_kind_o),
    .rec_time_o    (rec_time_o),
    .rec_pc_o      (rec_pc_o),
    .rec_target_o  (rec_target_o),
    .rec_data_o    (rec_data_o),
    .reg_cnt_o     (reg_cnt_o),
    .mem_cnt_o     (mem_cnt_o),
    .desync_o      (desync_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_char(input logic [7:0] c, input logic [1:0] ft);
    char_i        = c;
    format_type_i = ft;
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i], 2'd0);
  endtask

  task automatic check_rec(input string tag, input logic [1:0] kind, input logic [15:0] t,
                           input logic [31:0] pc, input logic [31:0] tgt, input logic [31:0] d);
    check({tag, "_valid"},  rec_valid_o,  1'b1);
    check({tag, "_kind"},   rec_kind_o,   kind);
    check({tag, "_time"},   rec_time_o,   t);
    check({tag, "_pc"},     rec_pc_o,     pc);
    check({tag, "_target"}, rec_target_o, tgt);
    check({tag, "_data"},   rec_data_o,   d);
  endtask

  initial begin
    reset_i = 1'b1;
    send_char(8'h00, 2'd0);
    send_char(8'h00, 2'd0);
    check("rst_valid",  rec_valid_o,  1'b0);
    check("rst_kind",   rec_kind_o,   2'd0);
    check("rst_time",   rec_time_o,   16'd0);
    check("rst_pc",     rec_pc_o,     32'd0);
    check("rst_target", rec_target_o, 32'd0);
    check("rst_data",   rec_data_o,   32'd0);
    check("rst_cnts",   {reg_cnt_o, mem_cnt_o, desync_o}, 5'd0);
    reset_i = 1'b0;

    // memory record
    send_str("^10@00003000: *00000004 <= 0000abcd#");
    send_char(" ", 2'd0);
    check("mem_pre_valid", rec_valid_o, 1'b0);
    send_str("^10@00003000: *00000004 <= 0000abcd#");
    send_char(" ", 2'd2);
    check_rec("mem", 2'd2, 16'd10, 32'h3000, 32'h4, 32'habcd);
    check("mem_memcnt", mem_cnt_o, 2'd1);
    check("mem_regcnt", reg_cnt_o, 2'd0);
    send_char(" ", 2'd0);
    check("mem_pulse_end", rec_valid_o, 1'b0);
    check("mem_hold_data", rec_data_o, 32'habcd);

    // register record
    send_str("^7@00003004: $31<=deadbeef#");
    send_char(" ", 2'd1);
    check_rec("reg", 2'd1, 16'd7, 32'h3004, 32'd31, 32'hdeadbeef);
    check("reg_regcnt", reg_cnt_o, 2'd1);
    check("reg_memcnt", mem_cnt_o, 2'd1);

    // back-to-back: second '^' arrives on the commit edge
    send_str("^1@a: *b <= c#");
    send_char("^", 2'd2);
    check_rec("b2b1", 2'd2, 16'd1, 32'ha, 32'hb, 32'hc);
    check("b2b1_memcnt", mem_cnt_o, 2'd2);
    send_str("2@d: $5<=e#");
    send_char(" ", 2'd1);
    check_rec("b2b2", 2'd1, 16'd2, 32'hd, 32'd5, 32'he);
    check("b2b2_regcnt", reg_cnt_o, 2'd2);
    check("b2b_desync", desync_o, 1'b0);

    // rejected record: checker verdict stays 0
    send_str("^5@3000:*1<=2#");
    send_char(" ", 2'd0);
    send_char(" ", 2'd0);
    check("rej_valid", rec_valid_o, 1'b0);
    check("rej_time",  rec_time_o, 16'd2);
    check("rej_data",  rec_data_o, 32'he);
    check("rej_cnts",  {reg_cnt_o, mem_cnt_o}, {2'd2, 2'd2});

    // reset mid-record
    send_str("^9@");
    reset_i = 1'b1;
    send_char(" ", 2'd0);
    check("mrst_time", rec_time_o, 16'd0);
    check("mrst_data", rec_data_o, 32'd0);
    check("mrst_cnts", {reg_cnt_o, mem_cnt_o, desync_o, rec_valid_o}, 6'd0);
    reset_i = 1'b0;
    send_str("3000: *1 <= 2#");
    send_char(" ", 2'd0);
    check("mrst_nocommit", rec_valid_o, 1'b0);
    send_str("^3@1: *2 <= 3#");
    send_char(" ", 2'd2);
    check_rec("clean", 2'd2, 16'd3, 32'h1, 32'h2, 32'h3);
    check("clean_memcnt", mem_cnt_o, 2'd1);

    // desync: verdict while in IDLE
    send_char(" ", 2'd2);
    check("desync_valid", rec_valid_o, 1'b0);
    check("desync_flag",  desync_o, 1'b1);
    check("desync_memcnt", mem_cnt_o, 2'd1);

    // kind disagreement: '$' record with mem verdict counts as mem
    send_str("^65535@ffffffff: $1<=1#");
    send_char(" ", 2'd2);
    check_rec("disagree", 2'd2, 16'd65535, 32'hffffffff, 32'd1, 32'h1);
    check("disagree_memcnt", mem_cnt_o, 2'd2);
    check("disagree_regcnt", reg_cnt_o, 2'd0);

    // saturation at 3 with CNT_W=2
    send_str("^1@1: *1 <= 1#");
    send_char(" ", 2'd2);
    check("sat_memcnt3", mem_cnt_o, 2'd3);
    send_str("^65536@123456789: *1 <= 1#");
    send_char(" ", 2'd2);
    check("sat_trunc_time", rec_time_o, 16'd0);
    check("sat_trunc_pc",   rec_pc_o, 32'h23456789);
    check("sat_hold", mem_cnt_o, 2'd3);
    check("sat_desync_sticky", desync_o, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_record_extractor.md
Name: cpu_record_extractor

Overview:
- Downstream companion of the trace-format checker. Receives the same 8-bit character stream, one char per clock, plus the checker's registered `format_type`.
- Tentatively decodes the fields of each trace record, `^<time>@<pc>: *<addr> <= <data>#` or `^<time>@<pc>: $<reg> <= <data>#`.
- Commits the decoded fields, and bumps per-kind counters, only when the checker validates the record.

Parameters:
- CNT_W, 16, width of the saturating record counters.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- char  input  8  ASCII character, sampled every rising edge
- format_type  input  2  checker verdict: 0 none, 1 register record, 2 memory record; pulses for 1 cycle, the cycle after `#` is sampled
- rec_valid  output  1  one-cycle pulse, committed record present
- rec_kind  output  2  copy of format_type at commit (1 reg, 2 mem); holds until next commit
- rec_time  output  16  decimal time field, binary
- rec_pc  output  32  pc field
- rec_target  output  32  memory address, or register number zero-extended
- rec_data  output  32  write data
- reg_cnt  output  CNT_W  committed register records, saturating
- mem_cnt  output  CNT_W  committed memory records, saturating
- desync  output  1  sticky: format_type!=0 seen while not in DONE

Behaviour:
- **Reset:** one clock; reset is synchronous and active-high. Every output is 0, the FSM goes to IDLE, and all shadow registers are 0. Reset has priority over everything, including mid-record; a partial record is discarded.
- **FSM states:** IDLE, TIME, PC, SEP, TGT, ARROW, EQ, DATA, DONE.
- **IDLE:**
  - `^` → TIME; clear the shadow time/pc/target/data and the kind flag.
  - any other char → IDLE.
- **TIME:**
  - digit 0-9 → time = time*10 + d, truncated to 16 bits.
  - `@` → PC.
  - else → IDLE.
- **PC:**
  - hex digit 0-9/a-f (lowercase only) → pc = {pc[27:0], nibble}.
  - `:` → SEP.
  - else → IDLE.
- **SEP:**
  - space → stay.
  - `*` → TGT, kind=mem.
  - `$` → TGT, kind=reg.
  - else → IDLE.
- **TGT:**
  - mem kind: hex digit shifts into target as for pc.
  - reg kind: decimal digit gives target = target*10 + d.
  - space → ARROW.
  - `<` → EQ.
  - other char → IDLE.
- **ARROW:**
  - space → stay.
  - `<` → EQ.
  - else → IDLE.
- **EQ:**
  - `=` → DATA.
  - else → IDLE.
- **DATA:**
  - leading spaces are allowed only before the first digit.
  - hex digit shifts into data.
  - `#` → DONE.
  - else → IDLE.
- **DONE:**
  - always leaves next cycle.
  - `^` → TIME, with the shadow cleared as in IDLE.
  - else → IDLE.
- **No length checks:** digit-count and length checking is the checker's job. Overlong fields simply shift/truncate. Invalid records never commit, because format_type stays 0.
- **Commit:** at any edge where format_type != 0 and state == DONE:
  - rec_* are loaded from the shadow values as they stood before that edge;
  - rec_kind = format_type;
  - rec_valid = 1 for exactly one cycle;
  - reg_cnt or mem_cnt increments, holding at all-ones.
  - Latency: rec_valid is high the cycle after the format_type pulse, i.e. two cycles after `#` is sampled.
- **Simultaneous `^` and commit:** commit uses the old shadow; the shadow clear and the TIME entry take effect in the same edge. Back-to-back records lose nothing.
- **Desync:** format_type != 0 while not in DONE → no commit, no count, desync=1 until reset.
- **Kind disagreement:** if format_type disagrees with the shadow kind, format_type wins for rec_kind and the counter choice.
- **Output hold:** outputs other than rec_valid hold their last committed values.

Decomposition:
- Shared package holds:
  - FSM state encodings;
  - ASCII constants `^ @ : * $ < = #` and space;
  - format_type codes NONE=0, REG=1, MEM=2.
- Sub-module `ascii_digit_decode`: combinational char → {is_dec, is_hex, nibble[3:0]}. It is reusable by the checker.

Test Plan:
- **Memory record:** `^10@00003000: *00000004 <= 0000abcd#`, format_type=2 pulsed the cycle after `#` → next cycle rec_valid=1, rec_kind=2, rec_time=10, rec_pc=0x3000, rec_target=0x4, rec_data=0xabcd, mem_cnt=1.
- **Register record:** `^7@00003004: $31<=deadbeef#`, format_type=1 → rec_target=31, rec_data=0xdeadbeef, rec_time=7, reg_cnt=1, mem_cnt unchanged.
- **Back-to-back:** two valid records with the second `^` on the commit edge → two rec_valid pulses, each carrying its own fields, and no desync.
- **Rejected record:** malformed record (`^5@3000:*1<=2#`), format_type held 0 → no rec_valid, outputs and counters unchanged.
- **Reset mid-record:** reset asserted after `@`, then a clean memory record → only the clean record commits; outputs are 0 during reset.
- **Desync and saturation:** format_type=2 while in IDLE → desync=1, no commit. With CNT_W=2, four mem commits → mem_cnt stays at 3.
